// File: rtl/nested_loop_counter_if.sv
// Control/status bundle for nested_loop_counter: start/en/abort and the
// latched end values in, per-level counts and loop status out.
interface nested_loop_counter_if #(
    parameter int WIDTH  = 16,
    parameter int LEVELS = 3
);
    logic                      start;
    logic                      en;
    logic                      abort;
    logic [LEVELS*WIDTH-1:0]   end_count;
    logic [LEVELS*WIDTH-1:0]   cnt;
    logic [LEVELS-1:0]         carry;
    logic                      last;
    logic                      busy;
    logic                      done;

    modport master (
        output start, en, abort, end_count,
        input  cnt, carry, last, busy, done
    );

    modport slave (
        input  start, en, abort, end_count,
        output cnt, carry, last, busy, done
    );
endinterface

// File: rtl/nested_loop_counter.sv
// Nested loop counter: LEVELS odometer-style counters, level 0 innermost,
// each wrapping at its own inclusive end value latched when the nest starts.
module nested_loop_counter #(
    parameter int WIDTH  = 16,
    parameter int LEVELS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    nested_loop_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1'b1);

    state_t                    state_r;
    state_t                    state_next_s;
    logic [LEVELS*WIDTH-1:0]   cnt_r;
    logic [LEVELS*WIDTH-1:0]   cnt_next_s;
    logic [LEVELS*WIDTH-1:0]   cnt_adv_s;
    logic [LEVELS*WIDTH-1:0]   end_r;
    logic [LEVELS*WIDTH-1:0]   end_next_s;
    logic                      busy_r;
    logic                      done_r;
    logic [LEVELS-1:0]         eq_s;
    logic [LEVELS-1:0]         match_s;
    logic [LEVELS-1:0]         carry_s;
    logic                      run_s;
    logic                      last_s;

    // Per-level terminal compare against the latched end values
    always_comb begin
        eq_s = '0;
        for (int i = 0; i < LEVELS; i++) begin
            eq_s[i] = (cnt_r[i*WIDTH +: WIDTH] == end_r[i*WIDTH +: WIDTH]);
        end
    end

    // match_s[i]: levels 0..i all sit at their end value (prefix AND)
    always_comb begin
        logic acc;
        acc     = 1'b1;
        match_s = '0;
        for (int i = 0; i < LEVELS; i++) begin
            acc        = acc & eq_s[i];
            match_s[i] = acc;
        end
    end

    // Status decode: carries only ripple on an en step while running
    always_comb begin
        run_s   = (state_r == RUN);
        carry_s = (run_s && bus.en) ? match_s : '0;
        last_s  = run_s && match_s[LEVELS-1];
    end

    // Odometer advance: a level steps when every lower level wraps
    always_comb begin
        cnt_adv_s = cnt_r;
        for (int i = 0; i < LEVELS; i++) begin
            if (match_s[i]) begin
                cnt_adv_s[i*WIDTH +: WIDTH] = '0;
            end else if ((i == 0) || match_s[(i > 0) ? i-1 : 0]) begin
                cnt_adv_s[i*WIDTH +: WIDTH] = cnt_r[i*WIDTH +: WIDTH] + CNT_ONE;
            end else begin
                cnt_adv_s[i*WIDTH +: WIDTH] = cnt_r[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-count selection; abort outranks en
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        end_next_s   = end_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = RUN;
                    end_next_s   = bus.end_count;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next_s = IDLE;
                    cnt_next_s   = '0;
                end else if (bus.en) begin
                    if (last_s) begin
                        state_next_s = DONE;
                        cnt_next_s   = '0;
                    end else begin
                        state_next_s = RUN;
                        cnt_next_s   = cnt_adv_s;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                cnt_next_s   = '0;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State, counts, latched ends and registered status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            end_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            end_r   <= end_next_s;
            busy_r  <= (state_next_s == RUN) || (state_next_s == DONE);
            done_r  <= (state_next_s == DONE);
        end
    end

    assign bus.cnt   = cnt_r;
    assign bus.carry = carry_s;
    assign bus.last  = last_s;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

endmodule
